exec_result_buffer: RTL and testbench
=====================================

# exec_result_buffer

Two-entry skid buffer between the execute stage and the memory stage. It consumes the ALU result, which carries the bitwise, add/sub and shift outputs selected by the ALU mux, together with the store operand and writeback controls. It decouples the two stages with a valid/ready handshake so memory-stage stalls do not create a combinational ready path back into execute. Arithmetic-overflow results are rewritten into a $rstatus write on capture.

## Interface
- No parameters; all widths come from `exec_pkg`.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of all buffered entries, for branch mispredict or jump.
- `in_valid`  in  1  execute stage presents an entry.
- `in_ready`  out  1  buffer accepts an entry; registered.
- `in_result`  in  32  ALU or multdiv result.
- `in_b`  in  32  store data operand.
- `in_rd`  in  5  destination register.
- `in_we`  in  1  register write enable.
- `in_mem_wr`  in  1  store enable.
- `in_ovf`  in  1  overflow flag from the ALU or multdiv.
- `in_exc_code`  in  3  $rstatus code for this instruction (add=1, addi=2, sub=3, mul=4, div=5, other=0).
- `out_valid`  out  1  head entry valid.
- `out_ready`  in  1  memory stage accepts the head entry.
- `out_result`, `out_b`  out  32 each  head entry fields.
- `out_rd`  out  5  head entry field.
- `out_we`, `out_mem_wr`  out  1 each  head entry fields.

## Operation
- Fire conditions: `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Storage: main register (drives `out_*`) and skid register. Occupancy state is EMPTY, ONE or TWO.
- In EMPTY:
  - `in_fire` loads main and moves to ONE.
- In ONE:
  - `in_fire` with `out_fire`: load main, stay in ONE.
  - `in_fire` only: load skid, move to TWO.
  - `out_fire` only: move to EMPTY.
- In TWO:
  - `in_ready` is 0.
  - `out_fire`: main takes skid, move to ONE.
- Ready rule: `in_ready` is 1 in EMPTY and ONE, 0 in TWO. It is driven from the state register only and never depends combinationally on `out_ready`.
- Capture rewrite: applies when `in_ovf` is 1 and `in_exc_code` is nonzero.
  - Stored result is `in_exc_code` zero-extended to 32 bits.
  - rd = 30, we = 1, mem_wr = 0.
  - `in_b` is stored unchanged.
- `in_ovf` with `in_exc_code` = 0 is ignored.
- Rewrite happens at capture, never at output.
- Flush has priority over every other event. The next edge forces EMPTY, and an `in_fire` in the flush cycle is dropped.
- Order is preserved: strictly FIFO, no reordering or duplication.

## Timing
- Reset values: state EMPTY, `out_valid` 0, `in_ready` 1, all `out_*` data and control fields 0.
- Reset is asynchronous and may assert mid-transfer. Both entries are discarded and no partial entry survives.
- Latency: an entry accepted at edge N is visible on `out_*` with `out_valid` = 1 after edge N.
- Throughput: one entry per cycle while `out_ready` = 1.
- `out_*` values hold stable while `out_valid` = 1 and `out_ready` = 0.
- `in_ready` falls on the edge that enters TWO and rises on the edge that leaves TWO.
- Full (TWO) with `in_valid` held: no capture until the cycle after the first `out_fire`.
- Empty with `out_ready` = 1: `out_valid` stays 0 and no fire occurs.

## Configuration
- Macro: `EXEC_BUF_EXCEPTION_EN`.
- Defined: the capture rewrite operates as described.
- Undefined: no rewrite logic. `in_ovf` and `in_exc_code` are unused and entries are stored verbatim.

## Structure
- `exec_pkg` holds:
  - width constants: data 32, reg index 5, exc code 3;
  - `RSTATUS_REG` = 30;
  - exception code constants;
  - packed entry typedef with fields result, b, rd, we, mem_wr;
  - state enum EMPTY/ONE/TWO.
- Sub-module `exec_exc_rewrite`: combinational rewrite from the input fields to a packed entry. It is instantiated once ahead of both storage registers and is bypassed when the macro is undefined.

## Test plan
- Reset with no traffic: `in_ready` = 1, `out_valid` = 0, all outputs 0. Send `in_result` = 0x0000_00FF, rd = 4, we = 1 → one cycle later `out_result` = 0x0000_00FF, `out_rd` = 4, `out_valid` = 1.
- Backpressure: hold `out_ready` = 0 and send A = 1, B = 2, C = 3 on consecutive cycles → A and B accepted, `in_ready` = 0 from the third cycle. Raise `out_ready` → outputs A, B, C in order with no loss.
- Streaming: `out_ready` held at 1, 8 consecutive entries 10..17 → one output per cycle, 1-cycle latency, `in_ready` never drops.
- Overflow (macro on): add with `in_ovf` = 1, code 1, `in_result` = 0x8000_0000, `in_mem_wr` = 1 → out result 1, rd 30, we 1, mem_wr 0. Same stimulus with the macro off → result 0x8000_0000, rd and controls unchanged.
- Flush in TWO with `in_valid` = 1 the same cycle → next cycle `out_valid` = 0, `in_ready` = 1. The in-flight entry never appears.
- Assert `reset_n` low asynchronously mid-cycle while in ONE → `out_valid` drops immediately and outputs are 0. After release, a fresh entry passes normally.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared widths, register/exception constants, entry and occupancy types for the execute result buffer
package exec_pkg;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int EXC_W  = 3;
    localparam logic [REG_W-1:0] RSTATUS_REG = 5'd30;
    localparam logic [EXC_W-1:0] EXC_NONE = 3'd0;
    localparam logic [EXC_W-1:0] EXC_ADD  = 3'd1;
    localparam logic [EXC_W-1:0] EXC_ADDI = 3'd2;
    localparam logic [EXC_W-1:0] EXC_SUB  = 3'd3;
    localparam logic [EXC_W-1:0] EXC_MUL  = 3'd4;
    localparam logic [EXC_W-1:0] EXC_DIV  = 3'd5;
    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rd;
        logic              we;
        logic              mem_wr;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
endpackage

// File: rtl/exec_exc_rewrite.sv
// exec_exc_rewrite: packs execute-stage fields into a buffer entry, turning overflows into $rstatus writes
// Ports: result/b/rd/we/mem_wr raw fields; ovf, exc_code overflow info; entry packed output.
// Build option EXEC_BUF_EXCEPTION_EN enables the rewrite; otherwise fields pass through verbatim.
module exec_exc_rewrite
    import exec_pkg::*;
(
    input  logic [DATA_W-1:0] result,
    input  logic [DATA_W-1:0] b,
    input  logic [REG_W-1:0]  rd,
    input  logic              we,
    input  logic              mem_wr,
    input  logic              ovf,
    input  logic [EXC_W-1:0]  exc_code,
    output entry_t            entry
);
`ifdef EXEC_BUF_EXCEPTION_EN
    logic hit;
    assign hit   = ovf & (exc_code != EXC_NONE);
    // store data is kept so a later handler still sees the original operand
    assign entry = hit ? {{(DATA_W-EXC_W){1'b0}}, exc_code, b, RSTATUS_REG, 1'b1, 1'b0}
                       : {result, b, rd, we, mem_wr};
`else
    logic unused_exc;
    assign unused_exc = ^{ovf, exc_code};
    assign entry      = {result, b, rd, we, mem_wr};
`endif
endmodule

// File: rtl/exec_result_buffer.sv
// exec_result_buffer: two-entry skid buffer decoupling execute from memory with a registered ready
// Ports: clock, reset_n (async active-low), flush (sync squash); in_* execute-side entry with
// in_valid/in_ready; out_* head entry with out_valid/out_ready. Build option EXEC_BUF_EXCEPTION_EN.
module exec_result_buffer
    import exec_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_b,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_we,
    input  logic              in_mem_wr,
    input  logic              in_ovf,
    input  logic [EXC_W-1:0]  in_exc_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_b,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_we,
    output logic              out_mem_wr
);
    state_t state, state_n;
    entry_t main_q, skid_q, cap;
    logic in_fire, out_fire, load_main, load_skid;

    exec_exc_rewrite u_rewrite (
        .result   (in_result),
        .b        (in_b),
        .rd       (in_rd),
        .we       (in_we),
        .mem_wr   (in_mem_wr),
        .ovf      (in_ovf),
        .exc_code (in_exc_code),
        .entry    (cap)
    );

    // ready decodes the state register only, so out_ready never reaches in_ready combinationally
    assign in_ready  = state != TWO;
    assign out_valid = state != EMPTY;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign load_skid = in_fire & ~out_fire & (state == ONE);
    assign load_main = (in_fire & ((state == EMPTY) | out_fire)) | (out_fire & (state == TWO));
    assign {out_result, out_b, out_rd, out_we, out_mem_wr} = main_q;

    always_comb begin
        state_n = flush ? EMPTY :
                  state == EMPTY ? (in_fire ? ONE : EMPTY) :
                  state == ONE   ? (in_fire == out_fire ? ONE : in_fire ? TWO : EMPTY) :
                                   (out_fire ? ONE : TWO);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_n;
            if (!flush && load_main) main_q <= state == TWO ? skid_q : cap;
            if (!flush && load_skid) skid_q <= cap;
        end
    end
endmodule

// File: tb/tb_exec_result_buffer.sv
// tb_exec_result_buffer: randomized and directed checks of exec_result_buffer against a queue model
module tb_exec_result_buffer;
    logic        clock = 0, reset_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, out_we, out_mem_wr;
    logic [31:0] in_result = 0, in_b = 0, out_result, out_b;
    logic [4:0]  in_rd = 0, out_rd;
    logic        in_we = 0, in_mem_wr = 0, in_ovf = 0;
    logic [2:0]  in_exc_code = 0;
    logic [70:0] got, exp_e;
    logic [70:0] q[$];
    logic [31:0] seen[$];
    int vectors = 0, miscompares = 0;

    always #5 clock = ~clock;
    assign got = {out_result, out_b, out_rd, out_we, out_mem_wr};

    exec_result_buffer dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_b(in_b),
        .in_rd(in_rd), .in_we(in_we), .in_mem_wr(in_mem_wr), .in_ovf(in_ovf),
        .in_exc_code(in_exc_code), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_b(out_b), .out_rd(out_rd), .out_we(out_we),
        .out_mem_wr(out_mem_wr)
    );

    function automatic logic [70:0] model_entry();
`ifdef EXEC_BUF_EXCEPTION_EN
        if (in_ovf && in_exc_code != 0) return {29'd0, in_exc_code, in_b, 5'd30, 1'b1, 1'b0};
`endif
        return {in_result, in_b, in_rd, in_we, in_mem_wr};
    endfunction

    task automatic set_in(input logic [31:0] r, input logic [31:0] b, input logic [4:0] rd,
                          input logic we, input logic wr, input logic ovf, input logic [2:0] code);
        in_result = r; in_b = b; in_rd = rd; in_we = we; in_mem_wr = wr; in_ovf = ovf; in_exc_code = code;
    endtask

    // one clock of traffic; the model is a bounded queue of capacity two
    task automatic cycle(input logic v, input logic rdy, input logic fl);
        logic inf, outf;
        logic [70:0] e;
        in_valid = v; out_ready = rdy; flush = fl;
        inf = v && q.size() < 2;
        outf = rdy && q.size() > 0;
        e = model_entry();
        #4;
        if (out_valid && out_ready) seen.push_back(out_result);
        @(posedge clock); #1;
        if (fl) q.delete();
        else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back(e);
        end
        in_valid = 0; flush = 0;
    endtask

    task automatic test_reset();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01 || got !== '0) begin
            miscompares++; $display("FAIL reset_state: valid/ready=%b out=%h want 01/0", {out_valid, in_ready}, got);
        end
        set_in(32'h0000_00FF, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1, 0, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'hFF || out_rd !== 5'd4 || out_we !== 1'b1) begin
            miscompares++; $display("FAIL first_entry: valid=%b result=%h rd=%0d we=%b want 1/ff/4/1", out_valid, out_result, out_rd, out_we);
        end
        cycle(0, 1, 0);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL drain_first: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        seen.delete();
        for (int i = 1; i <= 3; i++) begin
            set_in(i, 32'd100 + i, 5'(i), 1'b1, 1'b0, 1'b0, 3'd0);
            cycle(1, 0, 0);
            vectors++;
            if (in_ready !== (i < 2) || out_valid !== 1'b1 || out_result !== 32'd1) begin
                miscompares++; $display("FAIL bp_fill%0d: ready=%b valid=%b result=%0d want %b/1/1", i, in_ready, out_valid, out_result, i < 2);
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(i < 2, 1, 0);
            vectors++;
            if ({out_valid, in_ready} !== {q.size() != 0, q.size() < 2} || (q.size() != 0 && got !== q[0])) begin
                miscompares++; $display("FAIL bp_drain%0d: vr=%b out=%h want %b%b/%h", i, {out_valid, in_ready}, got, q.size() != 0, q.size() < 2, q.size() != 0 ? q[0] : 71'd0);
            end
        end
        vectors++;
        if (seen.size() != 3 || seen[0] !== 32'd1 || seen[1] !== 32'd2 || seen[2] !== 32'd3) begin
            miscompares++; $display("FAIL bp_order: got %0d entries %p want 1,2,3", seen.size(), seen);
        end
    endtask

    task automatic test_streaming();
        for (int i = 10; i <= 17; i++) begin
            set_in(i, 32'h0, 5'(i), 1'b1, 1'b0, 1'b0, 3'd0);
            cycle(1, 1, 0);
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 32'(i)) begin
                miscompares++; $display("FAIL stream%0d: ready=%b valid=%b result=%0d want 1/1/%0d", i, in_ready, out_valid, out_result, i);
            end
        end
        cycle(0, 1, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL stream_end: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow();
        set_in(32'h8000_0000, 32'h1234, 5'd9, 1'b0, 1'b1, 1'b1, 3'd1);
`ifdef EXEC_BUF_EXCEPTION_EN
        exp_e = {32'd1, 32'h1234, 5'd30, 1'b1, 1'b0};
`else
        exp_e = {32'h8000_0000, 32'h1234, 5'd9, 1'b0, 1'b1};
`endif
        cycle(1, 0, 0);
        vectors++;
        if (got !== exp_e) begin
            miscompares++; $display("FAIL ovf_add: out=%h want %h", got, exp_e);
        end
        set_in(32'h7, 32'h55, 5'd3, 1'b1, 1'b0, 1'b1, 3'd0);
        cycle(1, 1, 0);
        vectors++;
        if (got !== {32'h7, 32'h55, 5'd3, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL ovf_code0: out=%h want verbatim", got);
        end
        set_in(32'h9, 32'h66, 5'd5, 1'b0, 1'b1, 1'b0, 3'd5);
        cycle(1, 1, 0);
        vectors++;
        if (got !== {32'h9, 32'h66, 5'd5, 1'b0, 1'b1}) begin
            miscompares++; $display("FAIL no_ovf_code5: out=%h want verbatim", got);
        end
        cycle(0, 1, 0);
    endtask

    task automatic test_flush();
        set_in(32'hA1, 0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0); cycle(1, 0, 0);
        set_in(32'hA2, 0, 5'd2, 1'b1, 1'b0, 1'b0, 3'd0); cycle(1, 0, 0);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL flush_full: ready=%b want 0", in_ready);
        end
        set_in(32'hA3, 0, 5'd3, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1, 0, 1);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_empty: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        cycle(0, 1, 0);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_ghost: valid=%b result=%h want 0", out_valid, out_result);
        end
        set_in(32'hB0, 0, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1, 1, 0);
        vectors++;
        if (out_valid !== 1'b1 || out_result !== 32'hB0) begin
            miscompares++; $display("FAIL flush_after: valid=%b result=%h want 1/b0", out_valid, out_result);
        end
        cycle(0, 1, 0);
    endtask

    task automatic test_async_reset();
        set_in(32'hC0, 32'hC1, 5'd7, 1'b1, 1'b1, 1'b0, 3'd0);
        cycle(1, 0, 0);
        #3 reset_n = 0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || got !== '0) begin
            miscompares++; $display("FAIL async_reset: valid=%b ready=%b out=%h want 0/1/0", out_valid, in_ready, got);
        end
        q.delete();
        @(negedge clock); reset_n = 1;
        @(posedge clock); #1;
        set_in(32'hD0, 32'hD1, 5'd8, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle(1, 1, 0);
        vectors++;
        if (out_valid !== 1'b1 || got !== {32'hD0, 32'hD1, 5'd8, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL post_reset: valid=%b out=%h", out_valid, got);
        end
        cycle(0, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom));
            cycle(1'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 15) == 0);
            vectors++;
            if ({out_valid, in_ready} !== {q.size() != 0, q.size() < 2} || (q.size() != 0 && got !== q[0])) begin
                miscompares++; $display("FAIL random%0d: vr=%b out=%h want %b%b/%h", i, {out_valid, in_ready}, got, q.size() != 0, q.size() < 2, q.size() != 0 ? q[0] : 71'd0);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock); reset_n = 1;
        @(posedge clock); #1;
        test_reset();
        test_backpressure();
        test_streaming();
        test_overflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
